// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending bits,
// optional write-to-read bypass and a full snapshot for the debug path.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr  [NRD],
  output logic [XLEN-1:0] rd_data  [NRD],
  output logic            rd_busy  [NRD],
  input  logic            wr_en    [NWR],
  input  logic [AW-1:0]   wr_addr  [NWR],
  input  logic [XLEN-1:0] wr_data  [NWR],
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
  output logic [XLEN-1:0] dbg_regs [NREG]
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs   [NREG];
  logic [NREG-1:0] pend;

  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_val [NREG];

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index enabled port wins. Register 0 never sees a hit.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int unsigned p = 0; p < NWR; p++) begin
        if (r != 0 && wr_en[p] && wr_addr[p] == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[p];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      if (BYP && wr_hit[rd_addr[i]])
        rd_data[i] = wr_val[rd_addr[i]];
      else
        rd_data[i] = regs[rd_addr[i]];
      rd_busy[i] = pend[rd_addr[i]] && !(BYP && wr_hit[rd_addr[i]]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
      pend <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_hit[r])
          regs[r] <= wr_val[r];
        // A new producer outranks both flush and a same-cycle writeback
        if (iss_en && iss_addr == AW'(r))
          pend[r] <= 1'b1;
        else if (flush || wr_hit[r])
          pend[r] <= 1'b0;
      end
    end
  end

  assign dbg_regs = regs;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one instance with two write ports and bypass, one with a
// single write port and no bypass, driven by a shared read/issue interface.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0]   rd_addr [2];
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            flush;

  logic [XLEN-1:0] a_rd_data [2];
  logic            a_rd_busy [2];
  logic            a_wr_en   [2];
  logic [AW-1:0]   a_wr_addr [2];
  logic [XLEN-1:0] a_wr_data [2];
  logic [XLEN-1:0] a_dbg     [NREG];

  logic [XLEN-1:0] b_rd_data [2];
  logic            b_rd_busy [2];
  logic            b_wr_en   [1];
  logic [AW-1:0]   b_wr_addr [1];
  logic [XLEN-1:0] b_wr_data [1];
  logic [XLEN-1:0] b_dbg     [NREG];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .dbg_regs(a_dbg)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .dbg_regs(b_dbg)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    a_wr_en = '{1'b0, 1'b0}; a_wr_addr = '{'0, '0}; a_wr_data = '{'0, '0};
    b_wr_en = '{1'b0};       b_wr_addr = '{'0};     b_wr_data = '{'0};
  endtask

  initial begin
    idle();
    rd_addr = '{'0, '0};
    #3;
    chk("rst_dbg_a10", a_dbg[10], 64'h0);
    #9 rst = 1'b0;   // released between edges
    tick();

    // Every address on both ports reads zero and not busy
    for (int i = 0; i < NREG; i++) begin
      rd_addr = '{AW'(i), AW'(NREG - 1 - i)};
      #1;
      chk("rst_a_d0", a_rd_data[0], 64'h0);
      chk("rst_a_d1", a_rd_data[1], 64'h0);
      chk("rst_a_b0", {63'h0, a_rd_busy[0]}, 64'h0);
      chk("rst_b_d1", b_rd_data[1], 64'h0);
      chk("rst_b_b1", {63'h0, b_rd_busy[1]}, 64'h0);
    end

    // x0 is hardwired
    rd_addr = '{5'd0, 5'd0};
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd0; a_wr_data[0] = 64'hDEAD;
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 5'd0; b_wr_data[0] = 64'hDEAD;
    #1;
    chk("x0_bypass_a", a_rd_data[0], 64'h0);
    tick(); idle(); #1;
    chk("x0_read_a", a_rd_data[0], 64'h0);
    chk("x0_read_b", b_rd_data[0], 64'h0);
    chk("x0_dbg_a", a_dbg[0], 64'h0);

    // Bypass versus stored read
    rd_addr[0] = 5'd5;
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd5; a_wr_data[0] = 64'h1234;
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 5'd5; b_wr_data[0] = 64'h1234;
    #1;
    chk("x5_same_a", a_rd_data[0], 64'h1234);
    chk("x5_same_b", b_rd_data[0], 64'h0);
    chk("x5_dbg_pre", a_dbg[5], 64'h0);
    tick(); idle(); #1;
    chk("x5_next_a", a_rd_data[0], 64'h1234);
    chk("x5_next_b", b_rd_data[0], 64'h1234);
    chk("x5_dbg_a", a_dbg[5], 64'h1234);

    // Two ports to one address: port 1 wins
    rd_addr[1] = 5'd7;
    a_wr_en = '{1'b1, 1'b1}; a_wr_addr = '{5'd7, 5'd7};
    a_wr_data = '{64'hAAAA, 64'h5555};
    #1;
    chk("x7_bypass", a_rd_data[1], 64'h5555);
    tick(); idle(); #1;
    chk("x7_stored", a_rd_data[1], 64'h5555);
    chk("x7_dbg", a_dbg[7], 64'h5555);

    // Distinct addresses on the two ports both land
    a_wr_en = '{1'b1, 1'b1}; a_wr_addr = '{5'd8, 5'd9};
    a_wr_data = '{64'h8888, 64'h9999};
    tick(); idle(); #1;
    chk("x8_dbg", a_dbg[8], 64'h8888);
    chk("x9_dbg", a_dbg[9], 64'h9999);

    // Issue sets busy from the next cycle; write clears it
    rd_addr[0] = 5'd3;
    iss_en = 1'b1; iss_addr = 5'd3;
    #1;
    chk("x3_iss_same", {63'h0, a_rd_busy[0]}, 64'h0);
    tick(); idle(); #1;
    chk("x3_busy_a", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("x3_busy_b", {63'h0, b_rd_busy[0]}, 64'h1);
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd3; a_wr_data[0] = 64'h42;
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 5'd3; b_wr_data[0] = 64'h42;
    #1;
    chk("x3_wr_busy_a", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("x3_wr_data_a", a_rd_data[0], 64'h42);
    chk("x3_wr_busy_b", {63'h0, b_rd_busy[0]}, 64'h1);
    chk("x3_wr_data_b", b_rd_data[0], 64'h0);
    tick(); idle(); #1;
    chk("x3_after_a", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("x3_after_b", {63'h0, b_rd_busy[0]}, 64'h0);
    chk("x3_data_b", b_rd_data[0], 64'h42);

    // Issue to x0 is ignored
    rd_addr[0] = 5'd0;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle(); #1;
    chk("x0_iss_busy", {63'h0, a_rd_busy[0]}, 64'h0);

    // Issue + write + flush on x4, with x6 also pending
    iss_en = 1'b1; iss_addr = 5'd6;
    tick(); idle();
    rd_addr = '{5'd4, 5'd6};
    iss_en = 1'b1; iss_addr = 5'd4; flush = 1'b1;
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd4; a_wr_data[0] = 64'h9;
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 5'd4; b_wr_data[0] = 64'h9;
    #1;
    chk("x6_busy_pre", {63'h0, a_rd_busy[1]}, 64'h1);
    chk("x4_bypass", a_rd_data[0], 64'h9);
    tick(); idle(); #1;
    chk("x4_pend_a", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("x4_data_a", a_rd_data[0], 64'h9);
    chk("x6_flush_a", {63'h0, a_rd_busy[1]}, 64'h0);
    chk("x4_pend_b", {63'h0, b_rd_busy[0]}, 64'h1);
    chk("x4_data_b", b_rd_data[0], 64'h9);
    chk("x6_flush_b", {63'h0, b_rd_busy[1]}, 64'h0);

    // Asynchronous reset mid-cycle with state and an in-flight write
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd10; a_wr_data[0] = 64'hFF;
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 5'd10; b_wr_data[0] = 64'hFF;
    iss_en = 1'b1; iss_addr = 5'd11;
    tick(); idle(); #1;
    rd_addr = '{5'd11, 5'd4};
    #1;
    chk("x10_dbg_a", a_dbg[10], 64'hFF);
    chk("x11_busy", {63'h0, a_rd_busy[0]}, 64'h1);
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd12; a_wr_data[0] = 64'h77;
    rst = 1'b1;
    #1;
    chk("arst_dbg_a10", a_dbg[10], 64'h0);
    chk("arst_dbg_b10", b_dbg[10], 64'h0);
    chk("arst_busy11", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("arst_busy4", {63'h0, a_rd_busy[1]}, 64'h0);
    chk("arst_data4", a_rd_data[1], 64'h0);
    tick();
    #2 rst = 1'b0;
    idle();
    tick(); #1;
    chk("arst_lost12", a_dbg[12], 64'h0);
    a_wr_en[0] = 1'b1; a_wr_addr[0] = 5'd13; a_wr_data[0] = 64'h5;
    tick(); idle(); #1;
    chk("post_rst_x13", a_dbg[13], 64'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the CPU core, with per-register pending (scoreboard) bits. It provides NRD combinational read ports, NWR synchronous write ports with fixed-priority conflict resolution, optional same-cycle write-to-read bypass, and a full register snapshot for the difftest/debug path. It sits between decode/issue, which reads operands and marks destinations pending, and writeback, which writes results and clears pending bits.

## Interface
- XLEN, 64, data width
- NREG, 32, number of architectural registers; power of two, ≥2
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored values only
- AW (localparam), $clog2(NREG), address width
---
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr[NRD]  in  AW  read addresses
- rd_data[NRD]  out  XLEN  read data (combinational)
- rd_busy[NRD]  out  1  addressed register is pending (combinational)
- wr_en[NWR]  in  1  write strobes
- wr_addr[NWR]  in  AW  write addresses
- wr_data[NWR]  in  XLEN  write data
- iss_en  in  1  mark a destination register pending
- iss_addr  in  AW  destination register to mark
- flush  in  1  clear all pending bits
- dbg_regs[NREG]  out  XLEN  registered contents of all registers

## Operation
- Storage: `regs[NREG]` of XLEN bits and `pend[NREG]` of 1 bit. Both are cleared asynchronously on rst.
- Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: on posedge clk, for each address the highest-index port p with `wr_en[p]` and a matching address wins. Lower-index ports to the same address are dropped.
- Read, BYPASS=1: if any port writes `rd_addr[i]` (≠0) this cycle, `rd_data[i]` is the winning port's `wr_data`. Otherwise it is `regs[rd_addr[i]]`.
- Read, BYPASS=0: `rd_data[i] = regs[rd_addr[i]]`.
- Pending-bit next state, per register r≠0, in priority order:
  1. `iss_en && iss_addr==r` → 1 (the new producer wins over both flush and a same-cycle write).
  2. `flush` → 0.
  3. Any enabled write to r → 0.
  4. Otherwise hold.
- `rd_busy[i] = pend[rd_addr[i]] && !(BYPASS && a same-cycle write to rd_addr[i])`. An issue in the same cycle does not affect `rd_busy` until the next cycle.
- `dbg_regs` reflects `regs` directly. It shows no bypass and is updated one cycle after a write.
- Out-of-range addresses cannot occur because NREG is a power of two.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr` and, with BYPASS, from `wr_*`).
- Write latency: 1 cycle. Data is stored at the next posedge and visible without bypass from the following cycle.
- Pending latency: an issue at edge k sets `pend`, and `rd_busy` reflects it from cycle k+1. A write at edge k clears `pend`, and with BYPASS=1 `rd_busy` already reads 0 in the write cycle.
- Reset: all `regs`=0, all `pend`=0, `rd_data`=0 (absent bypass), `rd_busy`=0, `dbg_regs` all 0.
- Reset mid-operation: an asynchronous assert clears all state immediately, and in-flight writes are lost. After deassert, the first edge behaves normally.
- No handshake. Writes and issues are single-cycle strobes, and the caller guarantees at most one issue per cycle.

## Test plan
- Reset, then read every address on all ports → data 0, busy 0. Write 0xDEAD to x0, then read x0 → 0.
- BYPASS=1: write x5=0x1234 while reading x5 in the same cycle → `rd_data`=0x1234 that cycle and the next. BYPASS=0: old value 0 in the write cycle, 0x1234 after.
- NWR=2: both ports write x7 (port0=0xAAAA, port1=0x5555) in one cycle → x7=0x5555. Bypass also returns 0x5555.
- Issue x3 → `rd_busy`=1 from the next cycle. Write x3=0x42 → busy 0 in the write cycle (BYPASS=1) and data 0x42.
- Same cycle: issue x4 + write x4=0x9 + flush → x4 holds 0x9 and stays pending. All other pending bits clear.
- Write x10=0xFF, assert rst asynchronously between edges → `dbg_regs[10]` becomes 0 immediately, and `pend` is all clear.
